pent1m_ports: RTL and testbench
===============================

PENT1M_PORTS -- requirements
Module: pent1m_ports

Interface
REQ-001 SHALL have parameters: none; all port addresses are fixed as given in Function.
REQ-002 SHALL have port: fclk  in  1  system clock (28 MHz).
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: zpos, zneg  in  1 each  one-fclk strobes marking Z80 clock rising/falling edges.
REQ-005 SHALL have ports: za  in  16  Z80 address; zd  in  8  Z80 data.
REQ-006 SHALL have ports: iorq_n, wr_n, m1_n  in  1 each  Z80 control.
REQ-007 SHALL have ports: dos_turn_on, dos_turn_off  in  1 each  OR of all four pagers' DOS strobes.
REQ-008 SHALL have port: atmF7_wr  out  1  one-fclk write strobe for ATM xxF7 ports.
REQ-009 SHALL have ports: pent1m_ROM  out  1;  pent1m_page  out  6;  pent1m_ram0_0  out  1;  pent1m_1m_on  out  1.
REQ-010 SHALL have ports: scr_page  out  1  7FFD bit 3;  dos  out  1  DOS ROM active.

Function
REQ-011 SHALL define io_wr = !iorq_n && !wr_n && m1_n, sampled into a register wr_seen at every fclk with zpos=1.
REQ-012 SHALL produce exactly one internal write event per IO write cycle: on an fclk where zpos=1, io_wr=1 and wr_seen=0.
REQ-013 Write event SHALL register in the same fclk edge; atmF7_wr and all register outputs SHALL change 1 fclk after the event edge (registered, latency 1).
REQ-014 Port 7FFD decode SHALL be za[15]==0 && za[1]==0 (partial decode).
REQ-015 Port EFF7 decode SHALL be za==16'hEFF7 (full decode).
REQ-016 ATM port decode SHALL be za[7:0]==8'hF7 && za[10:8]==3'b111 && za[13:12]==2'b11 (any za[15:14], any za[11]).
REQ-017 ATM port write SHALL assert atmF7_wr only when dos==1 at event time; otherwise ignored.
REQ-018 atmF7_wr SHALL be high for exactly one fclk per accepted event; never two consecutive cycles.
REQ-019 7FFD write, when not locked, SHALL latch: pent1m_page[2:0]=zd[2:0], scr_page=zd[3], pent1m_ROM=zd[4], pent1m_page[5:3]={zd[5],zd[7],zd[6]}.
REQ-020 lock flag SHALL set on an accepted 7FFD write with zd[5]=1 while pent1m_1m_on=0; lock cleared only by reset.
REQ-021 While lock=1 and pent1m_1m_on=0, 7FFD writes SHALL be ignored entirely; if pent1m_1m_on=1, lock SHALL be ignored.
REQ-022 EFF7 write SHALL set pent1m_1m_on=~zd[2], pent1m_ram0_0=zd[3]; unaffected by lock.
REQ-023 dos SHALL set on dos_turn_on, clear on dos_turn_off, evaluated every fclk; both high -> dos_turn_on wins.
REQ-024 dos update SHALL be independent of IO events; same-cycle IO event and DOS strobe both take effect.
REQ-025 Non-decoded addresses SHALL change no state and produce no strobe.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: pent1m_page=0, pent1m_ROM=0, scr_page=0, lock=0, pent1m_1m_on=1, pent1m_ram0_0=0, dos=0, atmF7_wr=0.
REQ-027 wr_seen SHALL reset to 1 so an IO write active at reset release generates no event.
REQ-028 Reset asserted mid-write or mid-strobe SHALL cancel the strobe immediately.

Verification
REQ-029 OUT 7FFD,0x17 after reset -> pent1m_page=6'h07, pent1m_ROM=1, scr_page=0, one event only despite write lasting many zpos.
REQ-030 OUT EFF7,0x04; OUT 7FFD,0x20; OUT 7FFD,0x03 -> 1m_on=0, lock=1, page stays 6'h20 cleared to {1,0,0,000}=6'h20, second write ignored.
REQ-031 dos=0, OUT 77F7,0xAA -> atmF7_wr never asserted; dos_turn_on pulse then same OUT -> exactly one fclk atmF7_wr pulse.
REQ-032 dos_turn_on and dos_turn_off high same fclk with dos=0 -> dos=1 next cycle.
REQ-033 OUT 7FFD,0xFF with 1m_on=1 -> pent1m_page=6'h3F, no lock; subsequent OUT 7FFD,0x00 -> page 0.
REQ-034 rst_n pulsed low during active OUT EFF7 held through release -> ram0_0=0, 1m_on=1, no event after release.

Source files
------------

// File: rtl/pent1m_ports.sv
// Pentagon-1024 style memory/port registers: 7FFD paging with lock, EFF7 config,
// DOS flag tracking and the ATM xxF7 write strobe. One write event per Z80 IO cycle.
module pent1m_ports (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        dos_turn_on,
  input  logic        dos_turn_off,
  output logic        atmF7_wr,
  output logic        pent1m_ROM,
  output logic [5:0]  pent1m_page,
  output logic        pent1m_ram0_0,
  output logic        pent1m_1m_on,
  output logic        scr_page,
  output logic        dos
);

  logic io_wr;
  logic wr_seen;
  logic wr_event;
  logic lock;
  logic hit_7ffd;
  logic hit_eff7;
  logic hit_atm;
  logic accept_7ffd;

  // Falling-edge strobe is not needed: the write is qualified on zpos only.
  logic unused_zneg;
  assign unused_zneg = zneg;

  assign io_wr    = !iorq_n && !wr_n && m1_n;
  assign wr_event = zpos && io_wr && !wr_seen;

  assign hit_7ffd = (za[15] == 1'b0) && (za[1] == 1'b0);
  assign hit_eff7 = (za == 16'hEFF7);
  assign hit_atm  = (za[7:0] == 8'hF7) && (za[10:8] == 3'b111) && (za[13:12] == 2'b11);

  // Lock only matters in 128K mode; with 1M extension on it is bypassed.
  assign accept_7ffd = wr_event && hit_7ffd && !(lock && !pent1m_1m_on);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_seen       <= 1'b1;
      atmF7_wr      <= 1'b0;
      pent1m_page   <= 6'd0;
      pent1m_ROM    <= 1'b0;
      scr_page      <= 1'b0;
      lock          <= 1'b0;
      pent1m_1m_on  <= 1'b1;
      pent1m_ram0_0 <= 1'b0;
      dos           <= 1'b0;
    end else begin
      if (zpos)
        wr_seen <= io_wr;

      atmF7_wr <= wr_event && hit_atm && dos;

      if (dos_turn_on)
        dos <= 1'b1;
      else if (dos_turn_off)
        dos <= 1'b0;

      if (accept_7ffd) begin
        pent1m_page <= {zd[5], zd[7], zd[6], zd[2:0]};
        scr_page    <= zd[3];
        pent1m_ROM  <= zd[4];
        if (zd[5] && !pent1m_1m_on)
          lock <= 1'b1;
      end

      if (wr_event && hit_eff7) begin
        pent1m_1m_on  <= ~zd[2];
        pent1m_ram0_0 <= zd[3];
      end
    end
  end

endmodule

// File: tb/tb_pent1m_ports.sv
// Directed bench for pent1m_ports: a vector table of OUT cycles with expected
// register state, followed by reset and DOS-strobe corner sequences.
module tb_pent1m_ports;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zpos = 1'b0;
  logic        zneg = 1'b0;
  logic [15:0] za = 16'h0000;
  logic [7:0]  zd = 8'h00;
  logic        iorq_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        m1_n = 1'b1;
  logic        dos_turn_on = 1'b0;
  logic        dos_turn_off = 1'b0;
  logic        atmF7_wr;
  logic        pent1m_ROM;
  logic [5:0]  pent1m_page;
  logic        pent1m_ram0_0;
  logic        pent1m_1m_on;
  logic        scr_page;
  logic        dos;

  pent1m_ports dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg),
    .za(za), .zd(zd), .iorq_n(iorq_n), .wr_n(wr_n), .m1_n(m1_n),
    .dos_turn_on(dos_turn_on), .dos_turn_off(dos_turn_off),
    .atmF7_wr(atmF7_wr), .pent1m_ROM(pent1m_ROM), .pent1m_page(pent1m_page),
    .pent1m_ram0_0(pent1m_ram0_0), .pent1m_1m_on(pent1m_1m_on),
    .scr_page(scr_page), .dos(dos)
  );

  always #18 fclk = ~fclk;

  // Z80 clock at fclk/4: zpos and zneg one-fclk strobes
  logic [1:0] phase = 2'd3;
  always @(posedge fclk) begin
    #1;
    phase = phase + 2'd1;
    zpos  = (phase == 2'd0);
    zneg  = (phase == 2'd2);
  end

  // free-running strobe monitors; tests work on differences
  int   atm_total = 0;
  int   atm_double = 0;
  logic atm_prev = 1'b0;
  always @(negedge fclk) begin
    if (atmF7_wr) atm_total++;
    if (atmF7_wr && atm_prev) atm_double++;
    atm_prev = atmF7_wr;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic io_out(input logic [15:0] a, input logic [7:0] d);
    @(posedge fclk); #1;
    za = a; zd = d; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
    repeat (12) @(posedge fclk);
    #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (8) @(posedge fclk);
    #2;
  endtask

  task automatic dos_strobe(input logic on, input logic off);
    @(posedge fclk); #1;
    dos_turn_on = on; dos_turn_off = off;
    @(posedge fclk); #1;
    dos_turn_on = 1'b0; dos_turn_off = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [1:0]  dstb;   // bit0 = dos_turn_on, bit1 = dos_turn_off, pulsed before the OUT
    logic [5:0]  page;
    logic        rom;
    logic        scr;
    logic        one_m;
    logic        ram0;
    logic        dosv;
    int          atm;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int a0;
    int wait_cnt;
    // state carries from one vector to the next
    vecs[0]  = '{16'h7FFD, 8'h17, 2'd0, 6'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{16'h7FFD, 8'hFF, 2'd0, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{16'h7FFD, 8'h00, 2'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{16'h77F7, 8'hAA, 2'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{16'h77F7, 8'hAA, 2'd1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[5]  = '{16'h00FE, 8'h55, 2'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[6]  = '{16'hEFF7, 8'h04, 2'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[7]  = '{16'h7FFD, 8'h20, 2'd0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{16'h7FFD, 8'h03, 2'd0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[9]  = '{16'h1FFD, 8'h1F, 2'd0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[10] = '{16'hEFF7, 8'h08, 2'd0, 6'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    vecs[11] = '{16'h1FFD, 8'h05, 2'd0, 6'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    vecs[12] = '{16'hF7F7, 8'h33, 2'd2, 6'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[13] = '{16'hB7F7, 8'h11, 2'd3, 6'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    vecs[14] = '{16'h37FD, 8'h08, 2'd0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};

    repeat (3) @(posedge fclk);
    #2;
    chk("reset page", {2'b0, pent1m_page}, 8'h00);
    chk("reset rom", {7'b0, pent1m_ROM}, 8'h0);
    chk("reset scr", {7'b0, scr_page}, 8'h0);
    chk("reset 1m_on", {7'b0, pent1m_1m_on}, 8'h1);
    chk("reset ram0", {7'b0, pent1m_ram0_0}, 8'h0);
    chk("reset dos", {7'b0, dos}, 8'h0);
    chk("reset atm", {7'b0, atmF7_wr}, 8'h0);
    @(posedge fclk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge fclk);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].dstb != 2'd0) dos_strobe(vecs[i].dstb[0], vecs[i].dstb[1]);
      a0 = atm_total;
      io_out(vecs[i].a, vecs[i].d);
      $display("vec %0d: OUT %h,%h -> page=%h rom=%b scr=%b 1m=%b ram0=%b dos=%b atm=%0d",
               i, vecs[i].a, vecs[i].d, pent1m_page, pent1m_ROM, scr_page,
               pent1m_1m_on, pent1m_ram0_0, dos, atm_total - a0);
      chk($sformatf("v%0d page", i), {2'b0, pent1m_page}, {2'b0, vecs[i].page});
      chk($sformatf("v%0d rom", i), {7'b0, pent1m_ROM}, {7'b0, vecs[i].rom});
      chk($sformatf("v%0d scr", i), {7'b0, scr_page}, {7'b0, vecs[i].scr});
      chk($sformatf("v%0d 1m_on", i), {7'b0, pent1m_1m_on}, {7'b0, vecs[i].one_m});
      chk($sformatf("v%0d ram0", i), {7'b0, pent1m_ram0_0}, {7'b0, vecs[i].ram0});
      chk($sformatf("v%0d dos", i), {7'b0, dos}, {7'b0, vecs[i].dosv});
      chk($sformatf("v%0d atm pulses", i), 8'(atm_total - a0), 8'(vecs[i].atm));
    end

    // both DOS strobes in one fclk with dos=0: on wins, visible after one edge
    dos_strobe(1'b0, 1'b1);
    chk("dos cleared", {7'b0, dos}, 8'h0);
    @(posedge fclk); #1;
    dos_turn_on = 1'b1; dos_turn_off = 1'b1;
    @(posedge fclk); #2;
    dos_turn_on = 1'b0; dos_turn_off = 1'b0;
    $display("seq dual strobe: dos=%b", dos);
    chk("dual strobe dos", {7'b0, dos}, 8'h1);

    // reset while atmF7_wr is high drops it immediately
    @(posedge fclk); #1;
    za = 16'h77F7; zd = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    wait_cnt = 0;
    while (!atmF7_wr && wait_cnt < 40) begin
      @(negedge fclk);
      wait_cnt++;
    end
    chk("atm strobe seen", {7'b0, atmF7_wr}, 8'h1);
    #3;
    rst_n = 1'b0;
    #1;
    $display("seq reset mid strobe: atm=%b dos=%b", atmF7_wr, dos);
    chk("atm cancelled by reset", {7'b0, atmF7_wr}, 8'h0);
    chk("dos cleared by reset", {7'b0, dos}, 8'h0);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge fclk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge fclk);

    // reset during an active OUT EFF7 held through release: no event afterwards
    @(posedge fclk); #1;
    za = 16'hEFF7; zd = 8'h0C; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(posedge fclk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async reset 1m_on", {7'b0, pent1m_1m_on}, 8'h1);
    chk("async reset ram0", {7'b0, pent1m_ram0_0}, 8'h0);
    repeat (2) @(posedge fclk);
    #1;
    rst_n = 1'b1;
    repeat (16) @(posedge fclk);
    #2;
    $display("seq reset mid EFF7: 1m_on=%b ram0=%b", pent1m_1m_on, pent1m_ram0_0);
    chk("post-release 1m_on", {7'b0, pent1m_1m_on}, 8'h1);
    chk("post-release ram0", {7'b0, pent1m_ram0_0}, 8'h0);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (8) @(posedge fclk);
    #2;
    chk("after write end 1m_on", {7'b0, pent1m_1m_on}, 8'h1);
    chk("atm never two cycles", 8'(atm_double), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
